// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  localparam int BUFFER_DEPTH = 31;
  localparam int INSTR_W      = 32;

  // Committed buffer fill plus reads still in flight, kept 6 bits wide so
  // the sum can never wrap.
  function automatic logic [5:0] occupancy(input logic [4:0] fill,
                                           input logic [5:0] inflight);
    return {1'b0, fill} + inflight;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Memory read port and instruction buffer port of the fetch unit.
interface instruction_fetch_if
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W = 10
);

  logic [ADDR_W-1:0]  memAddr;
  logic               memRead;
  logic [INSTR_W-1:0] memData;
  logic               newInstruction;
  logic [INSTR_W-1:0] instructionIn;
  logic [4:0]         bufferFill;

  // Fetch unit side.
  modport master (
    output memAddr, memRead, newInstruction, instructionIn,
    input  memData, bufferFill
  );

  // Memory / instruction buffer side.
  modport slave (
    input  memAddr, memRead, newInstruction, instructionIn,
    output memData, bufferFill
  );

endinterface

// File: rtl/instruction_fetch_valid_pipe.sv
// Valid-tag shift register that tracks each issued read until its data
// comes back from the fixed-latency memory.
module fetch_valid_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetN,
  input  logic in_valid,
  output logic out_valid
);

  logic [DEPTH-1:0] pipe_r;

  // Shift a new tag in every cycle; reset drops all pending returns.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pipe_r <= '0;
    end else begin
      pipe_r <= (pipe_r << 1'b1) | DEPTH'(in_valid);
    end
  end

  assign out_valid = pipe_r[DEPTH-1];

endmodule

// File: rtl/instruction_fetch.sv
// Streams a contiguous program from instruction memory into the instruction
// buffer, throttled so buffer fill plus in-flight reads stays below a limit.
module instruction_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int MEM_LATENCY = 2,
  parameter int FILL_LIMIT  = 28
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   fetchedCount,
  instruction_fetch_if.master bus
);

  // In-flight never exceeds MEM_LATENCY; one spare code keeps it safe.
  localparam int IF_W = $clog2(MEM_LATENCY + 2);

  fetch_state_t       state_r;
  fetch_state_t       state_s;
  logic               suppress_r;
  logic               suppress_s;
  logic               busy_r;
  logic               done_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [ADDR_W:0]    len_r;
  logic [ADDR_W:0]    issued_r;
  logic [ADDR_W:0]    fetched_r;
  logic [IF_W-1:0]    inflight_r;
  logic               newinstr_r;
  logic [INSTR_W-1:0] instr_r;

  logic               accept_s;
  logic               issue_s;
  logic               ret_s;
  logic               deliver_s;
  logic [5:0]         occupancy_s;

  assign accept_s    = (state_r == IDLE) && start;
  assign occupancy_s = occupancy(bus.bufferFill, 6'(inflight_r));
  assign issue_s     = (state_r == FETCH) && (issued_r < len_r) && !abort &&
                       (occupancy_s < 6'(FILL_LIMIT));
  // An abort in the same cycle as a return already blocks that delivery.
  assign deliver_s   = ret_s && !suppress_r && !abort;

  fetch_valid_pipe #(
    .DEPTH (MEM_LATENCY)
  ) u_valid_pipe (
    .clk       (clk),
    .resetN    (resetN),
    .in_valid  (issue_s),
    .out_valid (ret_s)
  );

  // Next-state and suppress-flag logic.
  always_comb begin
    state_s    = state_r;
    suppress_s = suppress_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            state_s = DONE;
          end else begin
            state_s = FETCH;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (abort) begin
          state_s    = DRAIN;
          suppress_s = 1'b1;
        end else if (issued_r == len_r) begin
          state_s = DRAIN;
        end else begin
          state_s = FETCH;
        end
      end
      DRAIN: begin
        if (abort) begin
          suppress_s = 1'b1;
        end else begin
          suppress_s = suppress_r;
        end
        if (inflight_r == '0) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        state_s    = IDLE;
        suppress_s = 1'b0;
      end
      default: begin
        state_s    = IDLE;
        suppress_s = 1'b0;
      end
    endcase
  end

  // State register with busy/done registered from the next state.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r    <= IDLE;
      suppress_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      suppress_r <= suppress_s;
      busy_r     <= (state_s != IDLE);
      done_r     <= (state_s == DONE);
    end
  end

  // Program window latch and read address / issued-count advance.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      addr_r   <= '0;
      len_r    <= '0;
      issued_r <= '0;
    end else if (accept_s) begin
      addr_r   <= baseAddr;
      len_r    <= length;
      issued_r <= '0;
    end else if (issue_s) begin
      addr_r   <= addr_r + ADDR_W'(1);
      issued_r <= issued_r + (ADDR_W+1)'(1);
    end
  end

  // Reads outstanding in memory, suppressed or not.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      inflight_r <= '0;
    end else begin
      case ({issue_s, ret_s})
        2'b10:   inflight_r <= inflight_r + IF_W'(1);
        2'b01:   inflight_r <= inflight_r - IF_W'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Return path: capture delivered words and count them.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      newinstr_r <= 1'b0;
      instr_r    <= '0;
      fetched_r  <= '0;
    end else begin
      newinstr_r <= deliver_s;
      if (deliver_s) begin
        instr_r <= bus.memData;
      end
      if (accept_s) begin
        fetched_r <= '0;
      end else if (deliver_s) begin
        fetched_r <= fetched_r + (ADDR_W+1)'(1);
      end
    end
  end

  assign bus.memRead        = issue_s;
  assign bus.memAddr        = addr_r;
  assign bus.newInstruction = newinstr_r;
  assign bus.instructionIn  = instr_r;
  assign busy               = busy_r;
  assign done               = done_r;
  assign fetchedCount       = fetched_r;

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Upstream feeder for the core instruction buffer. On a start pulse it streams a contiguous program of 32-bit words from a fixed-latency instruction memory and presents each word to the buffer as a one-cycle `newInstruction` pulse. It throttles itself against the buffer's reported fill plus its own in-flight reads, so the 31-entry buffer never overflows.

## Interface
- `ADDR_W`, default 10: instruction memory address width.
- `MEM_LATENCY`, default 2: cycles from a sampled `memRead` to valid `memData`; legal range 1..4.
- `FILL_LIMIT`, default 28: maximum of committed buffer fill plus in-flight reads; must be ≤ 31.
- `clk` input, 1: single clock, rising edge.
- `resetN` input, 1: asynchronous, active-low reset.
- `start` input, 1: one-cycle request to fetch a program; ignored unless idle.
- `abort` input, 1: stop issuing and discard in-flight returns.
- `baseAddr` input, ADDR_W: first word address, latched on accepted start.
- `length` input, ADDR_W+1: number of words to fetch, latched on accepted start.
- `bufferFill` input, 5: current occupancy reported by the instruction buffer.
- `memAddr` output, ADDR_W: read address.
- `memRead` output, 1: read strobe, one word per cycle.
- `memData` input, 32: read data.
- `newInstruction` output, 1: one-cycle pulse, word valid on `instructionIn`.
- `instructionIn` output, 32: fetched word.
- `busy` output, 1: high in every state except IDLE.
- `done` output, 1: one-cycle pulse at end of program or abort.
- `fetchedCount` output, ADDR_W+1: words delivered since the last accepted start.

## Operation
- States:
  - IDLE: on `start`, latch `baseAddr` and `length`, clear `fetchedCount`. If `length`==0, go to DONE; otherwise go to FETCH.
  - FETCH: issue reads. When the issued count equals `length`, go to DRAIN. `abort` goes to DRAIN with the suppress flag set.
  - DRAIN: no reads. Go to DONE when in-flight count is 0. `abort` here sets the suppress flag.
  - DONE: `done`=1 for this cycle only, then go to IDLE.
- Issue rule in FETCH: `memRead`=1 iff issued < `length`, `abort`=0, and (`bufferFill` + inFlight) < FILL_LIMIT.
  - Compute this sum 6 bits wide, with no truncation.
- Address: `memAddr` = `baseAddr` + issued, modulo 2^ADDR_W. Wrap-around is legal and silent.
- In-flight counter: increments on issue and decrements on each return (suppressed or not). Simultaneous increment and decrement leaves it unchanged. Its width is sized for MEM_LATENCY+1.
- Return path: a valid-bit shift register of depth MEM_LATENCY tags each issued read.
  - When the tag emerges, register `memData` into `instructionIn`.
  - Pulse `newInstruction` unless suppress is set.
  - Increment `fetchedCount` only for non-suppressed words.
- Suppressed returns still decrement in-flight. `instructionIn` holds its last value when no word is delivered.
- `start` while busy: ignored, no side effects.
- The suppress flag clears on the entry to IDLE.

## Timing
- Reset values: `memRead`=0, `memAddr`=0, `newInstruction`=0, `instructionIn`=0, `busy`=0, `done`=0, `fetchedCount`=0, state IDLE, in-flight=0, valid pipe cleared.
- Reset asserted mid-operation discards any pending memory returns.
- Start accepted at edge t: first `memRead` is in cycle t+1 if not throttled.
- `memRead` in cycle r: `memData` valid in cycle r+MEM_LATENCY; `newInstruction` high in cycle r+MEM_LATENCY+1.
- Unthrottled throughput is one word per cycle.
- `done` asserts the cycle after the last `newInstruction` (DRAIN then DONE), so `busy` stays high through the last delivery.
- For `length`=0: `busy`=1 for exactly one cycle (DONE) with `done`=1.
- `abort` sampled at edge e: no `memRead` from cycle e+1 on, and no `newInstruction` from cycle e+1 on.

## Structure
- Package `instr_fetch_pkg` holds:
  - the state enum `fetch_state_t` (IDLE, FETCH, DRAIN, DONE);
  - the constant `BUFFER_DEPTH`=31;
  - the constant `INSTR_W`=32.
- One sub-module, `fetch_valid_pipe`: a parameterised MEM_LATENCY-deep valid shift register with async active-low reset. Everything else is in `instruction_fetch`.

## Test plan
- `baseAddr`=0x010, `length`=5, `bufferFill`=0, MEM_LATENCY=2, memory returning addr+0x100:
  - `memAddr` 0x010..0x014 on consecutive cycles;
  - five `newInstruction` pulses carrying 0x110..0x114;
  - `fetchedCount`=5, then one `done` pulse.
- `bufferFill` held at 27, `length`=4: at most 1 read in flight. After releasing `bufferFill` to 0, the remaining reads issue back-to-back. Exactly 4 words are delivered, in order.
- `baseAddr`=0x3FE, `length`=4, ADDR_W=10: `memAddr` sequence is 0x3FE, 0x3FF, 0x000, 0x001.
- `length`=20 with `abort` after the 6th `memRead`: no further reads. In-flight words are not delivered, `fetchedCount` ≤ 6, `done` pulses once, and `busy` drops.
- `length`=0: `done` one cycle after start, with no `memRead` and no `newInstruction`. A second `start` during a running fetch has no effect on count or address.
- `resetN` low mid-fetch with 2 reads in flight: all outputs go to reset values immediately, and no `newInstruction` appears after `resetN` is released.
